// File: rtl/bus_requester.sv
// bus_requester
//   Client-side agent for one req/gnt pair of a 4-way fixed-priority bus
//   arbiter. Local burst commands are queued. For each command the block
//   raises req, issues one beat per granted cycle and then releases the bus
//   for at least one cycle. It survives losing gnt mid-burst: the burst is
//   paused with req held, and it resumes when gnt returns.
//
// Optional feature (compile-time macro BUS_REQ_TIMEOUT_EN):
//   A burst is aborted after TIMEOUT consecutive req&&!gnt cycles. The abort
//   pulses timeout_err, drops the remaining beats and does not pulse done.
//   Without the macro there is no counter, timeout_err is tied 0, and the
//   block waits for gnt forever.
//
// Ports
//   clk          in   clock, all state on posedge
//   rst          in   synchronous active-high reset
//   cmd_valid    in   command offered
//   cmd_len      in   [BURST_W-1:0] beats-1 of the offered command
//   cmd_ready    out  queue can accept (count < DEPTH)
//   req          out  request to arbiter, registered
//   gnt          in   grant from arbiter (registered on the arbiter side)
//   beat         out  one bus beat this cycle (req && gnt)
//   done         out  pulse with the final beat of a burst
//   timeout_err  out  1-cycle pulse when a burst is aborted
//   pending      out  [$clog2(DEPTH):0] queued commands not yet started
module bus_requester #(
  parameter int BURST_W = 4,
  parameter int DEPTH   = 4
`ifdef BUS_REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [BURST_W-1:0]       cmd_len,
  output logic                     cmd_ready,
  output logic                     req,
  input  logic                     gnt,
  output logic                     beat,
  output logic                     done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = BURST_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OWN  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [BURST_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      rd_ptr_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [CW-1:0]      count_r;
  logic [RW-1:0]      rem_r;
  logic               req_r;
  logic               push_s;
  logic               pop_s;
  logic               busy_s;
  logic               beat_s;
  logic               last_s;
  logic               done_s;
  logic               tmo_s;

  // The queue accepts whenever it is not full.
  assign cmd_ready = (count_r < CW'(DEPTH));
  assign push_s    = cmd_valid && cmd_ready;

  // A gnt arriving while req is low (the arbiter's late grant after a
  // release) is masked here, so it can never produce a beat.
  assign beat_s = req_r && gnt;
  assign last_s = (rem_r == RW'(1'b1));
  assign done_s = beat_s && last_s;

`ifdef BUS_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_r;

  // The abort fires on the TIMEOUT-th consecutive starved cycle.
  assign tmo_s = busy_s && req_r && !gnt && (wait_r == WW'(TIMEOUT - 1));

  // Counts consecutive starved cycles; any beat or idle cycle clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r <= {WW{1'b0}};
    end else if (busy_s && req_r && !gnt) begin
      wait_r <= tmo_s ? {WW{1'b0}} : wait_r + WW'(1'b1);
    end else begin
      wait_r <= {WW{1'b0}};
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (count_r != CW'(1'b0)) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ, S_OWN: begin
        if (tmo_s) begin
          state_s = S_REL;
        end else if (beat_s && last_s) begin
          state_s = S_REL;
        end else if (beat_s) begin
          state_s = S_OWN;
        end else begin
          state_s = state_r;
        end
      end
      S_REL:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode of the current state.
  always_comb begin
    pop_s  = 1'b0;
    busy_s = 1'b0;
    case (state_r)
      S_IDLE:       pop_s  = (count_r != CW'(1'b0));
      S_REQ, S_OWN: busy_s = 1'b1;
      S_REL:        busy_s = 1'b0;
      default:      busy_s = 1'b0;
    endcase
  end

  // req rises one cycle after entering REQ. It falls on the edge that
  // leaves for REL, so the release gap starts right after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r <= 1'b0;
    end else begin
      req_r <= busy_s && ((state_s == S_REQ) || (state_s == S_OWN));
    end
  end

  // Queue storage. The contents need no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cmd_len;
    end
  end

  // Queue pointers, occupancy and the remaining-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      rem_r    <= {RW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (pop_s) begin
        rem_r <= RW'(mem_r[rd_ptr_r]) + RW'(1'b1);
      end else if (beat_s) begin
        rem_r <= rem_r - RW'(1'b1);
      end
    end
  end

  assign req         = req_r;
  assign beat        = beat_s;
  assign done        = done_s;
  assign timeout_err = tmo_s;
  assign pending     = count_r;

endmodule
